// File: rtl/alpha_blend_pipe_if.sv
`default_nettype none
// alpha_blend_pipe_if: pixel-stream, framebuffer and frame-marker signals of the blender.
// Revision: 1.0
interface alpha_blend_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);
  logic              pixel_ready;
  logic [ADDR_W-1:0] pixel_number;
  logic [DATA_W-1:0] r, g, b, a;
  logic [1:0]        mode;
  logic              in_full;
  logic              overflow;
  logic              read;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_r, read_g, read_b;
  logic              write;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_r, write_g, write_b;
  logic              frame_ready;
  logic              o_frame_ready;

  modport slave (
    input  pixel_ready, pixel_number, r, g, b, a, mode,
    input  read_r, read_g, read_b, frame_ready,
    output in_full, overflow, read, read_addr,
    output write, write_addr, write_r, write_g, write_b, o_frame_ready
  );

  modport master (
    output pixel_ready, pixel_number, r, g, b, a, mode,
    output read_r, read_g, read_b, frame_ready,
    input  in_full, overflow, read, read_addr,
    input  write, write_addr, write_r, write_g, write_b, o_frame_ready
  );
endinterface
`default_nettype wire

// File: rtl/alpha_blend_pipe.sv
`default_nettype none
// alpha_blend_pipe: queued read-modify-write pixel blender (alpha/additive/replace/multiply).
// Revision: 1.0
module alpha_blend_pipe #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  alpha_blend_pipe_if.slave bus
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (READ_LAT < 1) begin : g_bad_lat
    $error("READ_LAT must be at least 1");
  end

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 4 * DATA_W + 2;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int IW    = 2 * DATA_W + 1;

  localparam logic [1:0] MODE_ALPHA   = 2'b00;
  localparam logic [1:0] MODE_ADD     = 2'b01;
  localparam logic [1:0] MODE_REPLACE = 2'b10;
  localparam logic [1:0] MODE_MUL     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_BLEND = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  function automatic logic [DATA_W-1:0] blend_ch(
    input logic [DATA_W-1:0] s,
    input logic [DATA_W-1:0] d,
    input logic [DATA_W-1:0] al,
    input logic [1:0]        md
  );
    logic [IW-1:0] se, de, ae, mx, res;
    se  = IW'(s);
    de  = IW'(d);
    ae  = IW'(al);
    mx  = IW'({DATA_W{1'b1}});
    res = se;
    case (md)
      MODE_ALPHA: res = (se * ae + de * (mx - ae)) >> DATA_W;
      MODE_ADD: begin
        res = se + de;
        if (res > mx) res = mx;
      end
      MODE_MUL: res = (se * de) >> DATA_W;
      default:  res = se;
    endcase
    return res[DATA_W-1:0];
  endfunction

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, pending_q, pending_d;
  logic              push, pop, in_full, fifo_empty, frame_pulse;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_r, head_g, head_b, head_a;
  logic [1:0]        head_mode;

  state_e            state_q;
  logic [LAT_W-1:0]  wait_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] src_r_q, src_g_q, src_b_q, src_a_q;
  logic [DATA_W-1:0] dst_r_q, dst_g_q, dst_b_q;
  logic [1:0]        mode_q;
  logic              read_q, write_q;
  logic [ADDR_W-1:0] read_addr_q, write_addr_q;
  logic [DATA_W-1:0] write_r_q, write_g_q, write_b_q;

  assign in_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Fullness is judged before this cycle's pop, so a full queue never accepts.
  assign push       = bus.pixel_ready && !in_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign {head_addr, head_r, head_g, head_b, head_a, head_mode} = mem_q[rd_ptr_q];

  assign frame_pulse = pending_q && fifo_empty && (state_q == S_IDLE) && !push;
  assign pending_d   = frame_pulse ? 1'b0 : (pending_q | bus.frame_ready);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.pixel_number, bus.r, bus.g, bus.b, bus.a, bus.mode};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      if (bus.pixel_ready && in_full) overflow_q <= 1'b1;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      src_r_q      <= '0;
      src_g_q      <= '0;
      src_b_q      <= '0;
      src_a_q      <= '0;
      dst_r_q      <= '0;
      dst_g_q      <= '0;
      dst_b_q      <= '0;
      mode_q       <= MODE_ALPHA;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      write_r_q    <= '0;
      write_g_q    <= '0;
      write_b_q    <= '0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            addr_q  <= head_addr;
            src_r_q <= head_r;
            src_g_q <= head_g;
            src_b_q <= head_b;
            src_a_q <= head_a;
            mode_q  <= head_mode;
            if (head_mode == MODE_REPLACE) begin
              state_q <= S_BLEND;
            end else begin
              state_q     <= S_READ;
              read_q      <= 1'b1;
              read_addr_q <= head_addr;
            end
          end
        end
        S_READ: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        // Destination data is valid in the last of the READ_LAT wait cycles.
        S_WAIT: begin
          if (wait_cnt_q == LAT_W'(READ_LAT - 1)) begin
            dst_r_q <= bus.read_r;
            dst_g_q <= bus.read_g;
            dst_b_q <= bus.read_b;
            state_q <= S_BLEND;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_BLEND: begin
          write_r_q    <= blend_ch(src_r_q, dst_r_q, src_a_q, mode_q);
          write_g_q    <= blend_ch(src_g_q, dst_g_q, src_a_q, mode_q);
          write_b_q    <= blend_ch(src_b_q, dst_b_q, src_a_q, mode_q);
          write_addr_q <= addr_q;
          write_q      <= 1'b1;
          state_q      <= S_WRITE;
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_full       = in_full;
  assign bus.overflow      = overflow_q;
  assign bus.read          = read_q;
  assign bus.read_addr     = read_addr_q;
  assign bus.write         = write_q;
  assign bus.write_addr    = write_addr_q;
  assign bus.write_r       = write_r_q;
  assign bus.write_g       = write_g_q;
  assign bus.write_b       = write_b_q;
  assign bus.o_frame_ready = frame_pulse;

endmodule
`default_nettype wire

// File: tb/tb_alpha_blend_pipe.sv
`default_nettype none
// tb_alpha_blend_pipe: directed vectors with a write/read scoreboard and a framebuffer model.
// Revision: 1.0
module tb_alpha_blend_pipe;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 19;
  localparam int FIFO_DEPTH = 4;
  localparam int READ_LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alpha_blend_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  alpha_blend_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct { int addr; int r; int g; int b; int cyc; } wexp_t;
  typedef struct { int addr; int cyc; } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  wexp_t       mw;
  rexp_t       mr;
  logic [23:0] fb [512];
  int tests = 0, fails = 0, cyc = 0;
  int rd_age = -1, rd_idx = 0;
  int nwrites = 0, last_wr_cyc = -1, fr_cnt = 0, fr_cyc = -1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer: data only valid in the cycle READ_LAT after the strobe.
  always @(negedge clk) begin
    if (rd_age >= 0) rd_age = rd_age - 1;
    if (bus.read === 1'b1) begin
      rd_age = READ_LAT;
      rd_idx = int'(bus.read_addr[8:0]);
    end
    if (rd_age == 0) {bus.read_r, bus.read_g, bus.read_b} = fb[rd_idx];
    else             {bus.read_r, bus.read_g, bus.read_b} = {3{8'hA5}};
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.read === 1'b1) begin
        if (rq.size() == 0) check("read_when_none_pending", bus.read, 0);
        else begin
          mr = rq.pop_front();
          check("read_addr", bus.read_addr, mr.addr);
          if (mr.cyc >= 0) check("read_cycle", cyc, mr.cyc);
        end
      end
      if (bus.write === 1'b1) begin
        nwrites++;
        last_wr_cyc = cyc;
        if (wq.size() == 0) check("write_when_none_pending", bus.write, 0);
        else begin
          mw = wq.pop_front();
          check("write_addr", bus.write_addr, mw.addr);
          check("write_r", bus.write_r, mw.r);
          check("write_g", bus.write_g, mw.g);
          check("write_b", bus.write_b, mw.b);
          if (mw.cyc >= 0) check("write_cycle", cyc, mw.cyc);
        end
      end
      if (bus.o_frame_ready === 1'b1) begin
        fr_cnt++;
        fr_cyc = cyc;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.pixel_ready = 1'b0;
    bus.frame_ready = 1'b0;
  endtask

  // Presents one pixel for one cycle; expectations use hand-computed results.
  task automatic drive(input int addr, input int sr, input int sg, input int sb, input int sa,
                       input int md, input int er, input int eg, input int eb,
                       input bit timed, input bit accept);
    wexp_t we;
    rexp_t re;
    bus.pixel_ready  = 1'b1;
    bus.pixel_number = ADDR_W'(addr);
    bus.r = DATA_W'(sr);
    bus.g = DATA_W'(sg);
    bus.b = DATA_W'(sb);
    bus.a = DATA_W'(sa);
    bus.mode = 2'(md);
    if (accept) begin
      we.addr = addr; we.r = er; we.g = eg; we.b = eb;
      we.cyc  = timed ? ((md == 2) ? cyc + 3 : cyc + READ_LAT + 4) : -1;
      wq.push_back(we);
      if (md != 2) begin
        re.addr = addr;
        re.cyc  = timed ? cyc + 2 : -1;
        rq.push_back(re);
      end
    end
    cycles(1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (wq.size() != 0 || rq.size() != 0); i++) cycles(1);
    check("drain_pending_writes", wq.size(), 0);
    cycles(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, k;
    for (int i = 0; i < 512; i++) fb[i] = 24'h0;
    reset = 1'b0;
    idle();
    bus.pixel_number = '0;
    bus.r = '0; bus.g = '0; bus.b = '0; bus.a = '0; bus.mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", bus.read, 0);
    check("rst_write", bus.write, 0);
    check("rst_read_addr", bus.read_addr, 0);
    check("rst_write_addr", bus.write_addr, 0);
    check("rst_write_rgb", {bus.write_r, bus.write_g, bus.write_b}, 0);
    check("rst_frame", bus.o_frame_ready, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_in_full", bus.in_full, 0);
    reset = 1'b1;
    cycles(2);

    fb[100] = {8'd1, 8'd2, 8'd3};
    drive(100, 128, 64, 192, 17, 0, 9, 6, 15, 1, 1);
    idle(); wait_drain();

    fb[101] = {8'd255, 8'd170, 8'd0};
    drive(101, 0, 0, 0, 0, 0, 254, 169, 0, 1, 1);
    idle(); wait_drain();
    fb[102] = {8'd255, 8'd170, 8'd0};
    drive(102, 0, 0, 0, 255, 0, 0, 0, 0, 1, 1);
    idle(); wait_drain();

    fb[103] = {8'd100, 8'd20, 8'd0};
    drive(103, 200, 10, 0, 0, 1, 255, 30, 0, 1, 1);
    idle(); wait_drain();
    fb[104] = {8'd255, 8'd128, 8'd77};
    drive(104, 255, 128, 0, 0, 3, 254, 64, 0, 1, 1);
    idle(); wait_drain();
    drive(105, 5, 6, 7, 0, 2, 5, 6, 7, 1, 1);
    idle(); wait_drain();
    check("no_frame_pulse_yet", fr_cnt, 0);

    // Six back-to-back pushes into a 4-deep queue; the sixth must be dropped.
    n0 = nwrites;
    for (int i = 0; i < 6; i++) begin
      fb[200 + i] = {8'd1, 8'd2, 8'd3};
      if (i == 4) check("in_full_before_push5", bus.in_full, 0);
      if (i == 5) check("in_full_at_push6", bus.in_full, 1);
      drive(200 + i, 10 * (i + 1), 20, 30, 0, 1, 10 * (i + 1) + 1, 22, 33, i == 0, i < 5);
    end
    idle();
    check("overflow_set", bus.overflow, 1);
    wait_drain();
    cycles(10);
    check("overflow_sticky", bus.overflow, 1);
    check("overflow_write_count", nwrites - n0, 5);

    for (int i = 0; i < 3; i++) begin
      fb[300 + i] = {8'd100, 8'd100, 8'd100};
      drive(300 + i, i + 1, i + 1, i + 1, 0, 1, 101 + i, 101 + i, 101 + i, i == 0, 1);
    end
    bus.pixel_ready = 1'b0;
    bus.frame_ready = 1'b1;
    cycles(1);
    bus.frame_ready = 1'b0;
    cycles(3);
    check("no_early_frame", fr_cnt, 0);
    bus.frame_ready = 1'b1;
    cycles(1);
    bus.frame_ready = 1'b0;
    wait_drain();
    cycles(5);
    check("frame_pulse_count", fr_cnt, 1);
    check("frame_pulse_cycle", fr_cyc, last_wr_cyc + 1);

    // Abort a pixel in WAIT with a second one still queued.
    fb[400] = {8'd9, 8'd9, 8'd9};
    drive(400, 50, 50, 50, 128, 0, 0, 0, 0, 1, 1);
    drive(401, 60, 60, 60, 128, 0, 0, 0, 0, 0, 1);
    idle();
    cycles(1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_read", bus.read, 0);
    check("midrst_write", bus.write, 0);
    check("midrst_frame", bus.o_frame_ready, 0);
    check("midrst_in_full", bus.in_full, 0);
    check("midrst_overflow", bus.overflow, 0);
    wq.delete();
    rq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    n0 = nwrites;
    cycles(20);
    check("no_write_after_reset", nwrites - n0, 0);
    check("in_full_after_reset", bus.in_full, 0);
    bus.frame_ready = 1'b1;
    k = cyc;
    cycles(1);
    bus.frame_ready = 1'b0;
    cycles(3);
    check("empty_frame_pulse_count", fr_cnt, 2);
    check("empty_frame_pulse_cycle", fr_cyc, k + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alpha_blend_pipe.md
Name: alpha_blend_pipe

Overview:
- Parametrised successor to the single-pixel alpha blender.
- Queues incoming source pixels (RGBA plus per-pixel blend mode) in a small FIFO.
- For each pixel: read-modify-write on the framebuffer with a configurable read latency, blending in one of four modes.
- Signals frame completion only after every queued pixel has been written back.
- Sits between the rasteriser pixel stream and the framebuffer/SRAM controller.

Parameters:
- DATA_W, 8: bits per colour/alpha channel.
- ADDR_W, 19: pixel address width.
- FIFO_DEPTH, 4: input queue depth. Must be a power of 2, ≥2.
- READ_LAT, 2: cycles from the read-strobe cycle to the cycle in which read data is valid. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pixel_ready  in  1  source pixel valid this cycle.
- pixel_number  in  ADDR_W  target pixel address.
- r, g, b, a  in  DATA_W each  source colour and alpha.
- mode  in  2  blend mode: 00 alpha, 01 additive, 10 replace, 11 multiply.
- in_full  out  1  queue full; pixel_ready is ignored while high.
- overflow  out  1  sticky; set when a pixel arrives while in_full.
- read  out  1  framebuffer read strobe, one cycle.
- read_addr  out  ADDR_W  read address.
- read_r, read_g, read_b  in  DATA_W each  destination pixel data.
- write  out  1  framebuffer write strobe, one cycle.
- write_addr  out  ADDR_W  write address.
- write_r, write_g, write_b  out  DATA_W each  blended result.
- frame_ready  in  1  end-of-frame marker from upstream.
- o_frame_ready  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; FSM to IDLE; frame-pending flag cleared.
  - All outputs 0: read, write, addresses, write data, o_frame_ready, overflow. in_full=0.
  - In-flight pixel discarded; no write is issued after reset releases.
- Push: on a rising edge with pixel_ready=1 and in_full=0, {pixel_number, r, g, b, a, mode} enters the FIFO.
  - pixel_ready=1 with in_full=1: pixel dropped, overflow←1 until reset.
  - Simultaneous push and pop when full is not allowed; in_full is evaluated before the pop.
- in_full is high when the FIFO count equals FIFO_DEPTH.
- FSM states: IDLE, READ, WAIT, BLEND, WRITE.
  - IDLE: if the FIFO is non-empty, pop the head into a working register. Go to READ, or to BLEND if mode=10 (replace skips the read).
  - READ: read=1, read_addr=working address, for exactly 1 cycle. Go to WAIT.
  - WAIT: count READ_LAT cycles. Sample read_r/g/b at the end of cycle n+READ_LAT, where n is the READ cycle. Go to BLEND.
  - BLEND: compute and register the result. Go to WRITE.
  - WRITE: write=1, write_addr=working address, write_r/g/b valid, for exactly 1 cycle. Go to IDLE.
- Latency: pixel sampled at the end of cycle m.
  - Read modes: read in cycle m+2, write in cycle m+READ_LAT+4.
  - Replace: write in cycle m+3.
  - Throughput: one pixel per READ_LAT+4 cycles (3 for replace).
- Arithmetic, per channel. s=source, d=destination, MAX=2^DATA_W−1. Intermediates 2·DATA_W+1 bits, unsigned, truncating.
  - alpha: (s·a + d·(MAX−a)) >> DATA_W. Note a=0 yields d·MAX>>DATA_W, not d exactly.
  - additive: min(s+d, MAX).
  - multiply: (s·d) >> DATA_W.
  - replace: s.
- Frame: frame_ready=1 sets the frame-pending flag.
  - o_frame_ready pulses for 1 cycle in the first cycle where pending=1, the FIFO is empty, the FSM is in IDLE, and no push is happening; the flag then clears.
  - A pixel pushed in the same cycle as frame_ready belongs to that frame.
  - Repeated frame_ready while pending merges into a single pulse.
- write_r/g/b and write_addr hold their last value outside WRITE. read_addr holds its last value outside READ.

Test Plan:
- Alpha mode: r=128, g=64, b=192, a=17, dst=(1,2,3), mode=00, READ_LAT=2 → one write in cycle m+6 with (9,6,15), write_addr=pixel_number.
- Alpha extremes:
  - a=0, src=0, dst=(255,170,0) → (254,169,0).
  - a=255, src=0, same dst → (0,0,0).
- Other modes:
  - Additive: src (200,10,0), dst (100,20,0) → (255,30,0).
  - Multiply: src (255,128,0), dst (255,128,77) → (254,64,0).
  - Replace: src (5,6,7) → write in cycle m+3 with (5,6,7), read never asserted.
- Overflow: 6 back-to-back pushes with FIFO_DEPTH=4 and in_full ignored:
  - in_full rises after push 5.
  - Push 6 is dropped; overflow=1 and stays 1.
  - Exactly 5 writes occur, in order.
- Frame drain: 3 pixels queued, then frame_ready pulsed → o_frame_ready is a single pulse one cycle after the 3rd write, never earlier. A second frame_ready while pending yields no extra pulse.
- Reset mid-op: reset=0 during WAIT → read, write, o_frame_ready, in_full all 0 immediately. After release, no write is issued for the aborted pixel and the FIFO is empty.
